// File: rtl/axi_axis_mc_reader_pkg.sv
// axi_axis_mc_reader_pkg: shared response code, region encodings and status-word layout
package axi_axis_mc_reader_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic {REGION_DATA = 1'b0, REGION_STATUS = 1'b1} region_e;
  function automatic int status_empty_bit(int w);
    return w - 1;
  endfunction
endpackage

// File: rtl/axi_axis_mc_reader_if.sv
// axi_axis_mc_reader_if: AXI4-Lite register bus with master/slave modports
interface axi_axis_mc_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [DATA_W-1:0] wdata, rdata;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  modport slave (
    input awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
  );
  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
  );
endinterface

// File: rtl/axi_axis_mc_fifo.sv
// axi_axis_mc_fifo: single-channel prefetch FIFO with push, pop, flush (flush wins) and fill count
module axi_axis_mc_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    wp_d    = flush ? '0 : wp_q + AW'(push);
    rp_d    = flush ? '0 : rp_q + AW'(pop);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (push) mem[wp_q] <= din;
  assign dout  = mem[rp_q];
  assign count = count_q;
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/axi_axis_mc_reader.sv
// axi_axis_mc_reader: AXI4-Lite readout of CHANNELS stream FIFOs; AXI_AXIS_MC_READER_STATUS_EN adds status reads and flush writes
module axi_axis_mc_reader
  import axi_axis_mc_reader_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int CHANNELS       = 4,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                               aclk,
  input  logic                               areset,
  axi_axis_mc_reader_if.slave                s_axi,
  input  logic [CHANNELS*AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]                s_axis_tvalid,
  output logic [CHANNELS-1:0]                s_axis_tready
);
  localparam int W    = AXI_DATA_WIDTH;
  localparam int CW   = $clog2(CHANNELS);
  localparam int CIW  = CW > 0 ? CW : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  logic [CHANNELS-1:0] push, pop, flush, full, empty;
  logic [CHANNELS-1:0][W-1:0] dout;
  logic [CHANNELS-1:0][CNTW-1:0] cnt;
  logic [CIW-1:0] rch;
  region_e rreg;
  logic ar_hs, wr_hs, rvalid_d, rvalid_q, bvalid_d, bvalid_q, unused;
  logic [W-1:0] rval, rdata_d, rdata_q;
  assign rch   = CIW'((s_axi.araddr >> 2) & (CHANNELS - 1));
  assign rreg  = region_e'(s_axi.araddr[CW+2]);
  assign ar_hs = s_axi.arvalid & ~rvalid_q;
  assign wr_hs = s_axi.awvalid & s_axi.wvalid & ~bvalid_q;
`ifdef AXI_AXIS_MC_READER_STATUS_EN
  logic [CIW-1:0] wch;
  region_e wreg;
  assign wch  = CIW'((s_axi.awaddr >> 2) & (CHANNELS - 1));
  assign wreg = region_e'(s_axi.awaddr[CW+2]);
`endif
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign push[c] = s_axis_tvalid[c] & ~full[c];
    assign pop[c]  = ar_hs && rreg == REGION_DATA && rch == CIW'(c) && !empty[c];
`ifdef AXI_AXIS_MC_READER_STATUS_EN
    assign flush[c] = wr_hs && wreg == REGION_STATUS && s_axi.wdata[0] && wch == CIW'(c);
`else
    assign flush[c] = 1'b0;
`endif
    axi_axis_mc_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(aclk), .rst(areset), .push(push[c]), .pop(pop[c]), .flush(flush[c]),
      .din(s_axis_tdata[c*W +: W]), .dout(dout[c]), .count(cnt[c]),
      .full(full[c]), .empty(empty[c])
    );
  end
  // the head is sampled before the edge that may flush or pop it
  always_comb begin
    rval = '0;
    if (rreg == REGION_DATA) rval = empty[rch] ? '0 : dout[rch];
`ifdef AXI_AXIS_MC_READER_STATUS_EN
    else begin
      rval[CNTW-1:0] = cnt[rch];
      rval[status_empty_bit(W)] = empty[rch];
    end
`endif
    rdata_d  = ar_hs ? rval : rdata_q;
    rvalid_d = ar_hs | (rvalid_q & ~s_axi.rready);
    bvalid_d = wr_hs | (bvalid_q & ~s_axi.bready);
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      bvalid_q <= bvalid_d;
    end
  assign s_axis_tready = ~full;
  assign s_axi.arready = ~rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;
  assign s_axi.awready = wr_hs;
  assign s_axi.wready  = wr_hs;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = RESP_OKAY;
  assign unused = ^{s_axi.awaddr, s_axi.wdata, s_axi.araddr, cnt};
endmodule

// File: tb/tb_axi_axis_mc_reader.sv
// tb_axi_axis_mc_reader: directed checks of FIFO readout, status, flush, backpressure and reset
module tb_axi_axis_mc_reader;
`ifdef AXI_AXIS_MC_READER_STATUS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif
  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [127:0] tdata = '0;
  logic [3:0] tvalid = '0;
  logic [3:0] tready;
  logic [31:0] d;
  int tests = 0;
  int fails = 0;
  axi_axis_mc_reader_if #(.ADDR_W(16), .DATA_W(32)) s_axi ();
  axi_axis_mc_reader #(
    .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16), .CHANNELS(4), .FIFO_DEPTH(4)
  ) dut (
    .aclk(aclk), .areset(areset), .s_axi(s_axi),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready)
  );
  always #5 aclk = ~aclk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push(input int ch, input logic [31:0] v);
    tdata[ch*32 +: 32] = v;
    tvalid[ch] = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    tvalid[ch] = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, output logic [31:0] v);
    int n = 0;
    while (s_axi.arready !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    check("arready_wait", {31'd0, s_axi.arready}, 32'd1);
    s_axi.araddr = a;
    s_axi.arvalid = 1'b1;
    s_axi.rready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    s_axi.arvalid = 1'b0;
    check("rvalid", {31'd0, s_axi.rvalid}, 32'd1);
    v = s_axi.rdata;
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] v);
    s_axi.awaddr = a;
    s_axi.wdata = v;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid = 1'b1;
    s_axi.bready = 1'b0;
    #1 check("awready", {31'd0, s_axi.awready & s_axi.wready}, 32'd1);
    @(posedge aclk);
    @(negedge aclk);
    s_axi.awvalid = 1'b0;
    s_axi.wvalid = 1'b0;
    check("bvalid_set", {31'd0, s_axi.bvalid}, 32'd1);
    check("bresp", {30'd0, s_axi.bresp}, 32'd0);
    s_axi.bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    s_axi.bready = 1'b0;
    check("bvalid_clr", {31'd0, s_axi.bvalid}, 32'd0);
  endtask
  initial begin
    s_axi.awaddr = '0; s_axi.wdata = '0; s_axi.araddr = '0;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
    s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    #1;
    check("rst_tready", {28'd0, tready}, 32'hF);
    check("rst_arready", {31'd0, s_axi.arready}, 32'd1);
    check("rst_awready", {30'd0, s_axi.awready, s_axi.wready}, 32'd0);
    check("rst_valids", {30'd0, s_axi.rvalid, s_axi.bvalid}, 32'd0);
    check("rst_rdata", s_axi.rdata, 32'd0);
    @(negedge aclk);
    // two beats on ch2, then read past the end
    push(2, 32'hA1);
    push(2, 32'hA2);
    rd(16'h008, d); check("ch2_head", d, 32'hA1);
    check("rresp", {30'd0, s_axi.rresp}, 32'd0);
    rd(16'h008, d); check("ch2_second", d, 32'hA2);
    rd(16'h008, d); check("ch2_empty", d, 32'h0);
    // overfill ch0: fifth beat is refused
    for (int i = 0; i < 4; i++) push(0, 32'h10 + i);
    check("ch0_full_tready", {31'd0, tready[0]}, 32'd0);
    push(0, 32'h14);
    rd(16'h010, d); check("ch0_status_full", d, ST ? 32'h4 : 32'h0);
    rd(16'h000, d); check("ch0_pop", d, 32'h10);
    check("ch0_tready_back", {31'd0, tready[0]}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      rd(16'h000, d); check("ch0_order", d, 32'h10 + i);
    end
    rd(16'h000, d); check("ch0_dropped", d, 32'h0);
    // empty status, then flush a partly filled channel
    rd(16'h01C, d); check("ch3_status_empty", d, ST ? 32'h8000_0000 : 32'h0);
    for (int i = 0; i < 3; i++) push(1, 32'hB1 + i);
    rd(16'h014, d); check("ch1_status_3", d, ST ? 32'h3 : 32'h0);
    wr(16'h014, 32'h1);
    rd(16'h014, d); check("ch1_status_flushed", d, ST ? 32'h8000_0000 : 32'h0);
    rd(16'h004, d); check("ch1_after_flush", d, ST ? 32'h0 : 32'hB1);
    // rready backpressure holds the response and blocks the next read
    push(3, 32'hC1);
    push(3, 32'hC2);
    s_axi.araddr = 16'h00C;
    s_axi.arvalid = 1'b1;
    s_axi.rready = 1'b0;
    @(posedge aclk);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("hold_rvalid", {31'd0, s_axi.rvalid}, 32'd1);
      check("hold_arready", {31'd0, s_axi.arready}, 32'd0);
      check("hold_rdata", s_axi.rdata, 32'hC1);
    end
    s_axi.rready = 1'b1;
    @(negedge aclk);
    check("rel_arready", {31'd0, s_axi.arready}, 32'd1);
    @(negedge aclk);
    s_axi.arvalid = 1'b0;
    check("next_rvalid", {31'd0, s_axi.rvalid}, 32'd1);
    check("next_rdata", s_axi.rdata, 32'hC2);
    @(negedge aclk);
    // reset with a read and a write response both pending
    push(0, 32'hD1);
    push(0, 32'hD2);
    s_axi.araddr = 16'h00C;
    s_axi.arvalid = 1'b1;
    s_axi.rready = 1'b0;
    s_axi.awaddr = 16'h000;
    s_axi.wdata = 32'h0;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid = 1'b1;
    s_axi.bready = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    s_axi.arvalid = 1'b0;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid = 1'b0;
    check("pre_rst_pending", {30'd0, s_axi.rvalid, s_axi.bvalid}, 32'd3);
    areset = 1'b1;
    #1;
    check("mid_rst_valids", {30'd0, s_axi.rvalid, s_axi.bvalid}, 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    #1 check("post_rst_tready", {28'd0, tready}, 32'hF);
    @(negedge aclk);
    rd(16'h010, d); check("post_rst_status", d, ST ? 32'h8000_0000 : 32'h0);
    rd(16'h000, d); check("post_rst_data", d, 32'h0);
    @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_axis_mc_reader.md
AXI_AXIS_MC_READER -- requirements
Module: axi_axis_mc_reader

Interface
REQ-001 Parameter AXI_DATA_WIDTH, default 32: AXI data width and stream data width.
REQ-002 Parameter AXI_ADDR_WIDTH, default 16: AXI address width.
REQ-003 Parameter CHANNELS, default 4, power of two, 1..16: number of stream inputs.
REQ-004 Parameter FIFO_DEPTH, default 16, power of two, >=2: prefetch FIFO entries per channel.
REQ-005 aclk  in  1  sole clock; all logic on its rising edge.
REQ-006 areset  in  1  reset, asynchronous assert, active-high.
REQ-007 AXI4-Lite slave set s_axi_*: awaddr/araddr AXI_ADDR_WIDTH; wdata/rdata AXI_DATA_WIDTH; awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready 1; bresp, rresp 2.
REQ-008 s_axis_tdata  in  CHANNELS*AXI_DATA_WIDTH  packed data; channel c in bits [c*W +: W].
REQ-009 s_axis_tvalid  in  CHANNELS; s_axis_tready  out  CHANNELS: per-channel handshake.

Function
REQ-010 Address decode: CW=log2(CHANNELS); channel = addr[CW+1:2]; region = addr[CW+2] (0 data, 1 status); higher bits ignored.
REQ-011 Each channel SHALL own a FIFO_DEPTH FIFO; s_axis_tready[c] = not full; beat pushed when tvalid&tready.
REQ-012 Read: arready = ~rvalid (one outstanding); on ar handshake, rdata/rvalid registered next edge; rvalid held until rready, cleared on rvalid&rready.
REQ-013 Data-region read of non-empty channel SHALL return FIFO head and pop it at the ar handshake edge.
REQ-014 Data-region read of empty channel SHALL return 0, no pop, rresp OKAY.
REQ-015 Status-region read SHALL return {empty flag in bit W-1, fill count zero-extended in low bits}; no pop.
REQ-016 Write: awready=wready=1 only when awvalid&wvalid&~bvalid; accept both same edge; bvalid set next edge, held until bready; bresp OKAY.
REQ-017 Write to status region with wdata[0]=1 SHALL flush that channel (count 0) at the accept edge; other writes accepted, no effect.
REQ-018 Latency: beat pushed at edge k readable by an ar handshake at edge k+1 or later.
REQ-019 Simultaneous push and pop on a channel: count unchanged; full FIFO may push on pop edge only via tready of prior cycle (tready not combinational on pop).
REQ-020 Flush coincident with push: flush wins, beat discarded; flush coincident with pop: rdata returns pre-flush head, count 0.
REQ-021 Read and write paths independent; a read may complete while bvalid pending and vice versa.
REQ-022 Fill count width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-023 areset SHALL clear all FIFOs, rvalid, bvalid, rdata to 0; tready reads 1 after reset release; arready 1, awready/wready 0.
REQ-024 Reset mid-transaction SHALL abandon pending rvalid/bvalid without completion.

Configuration
REQ-025 Macro AXI_AXIS_MC_READER_STATUS_EN: defined -> status reads and flush writes per REQ-015/017.
REQ-026 Undefined -> status-region reads return 0, flush writes ignored, fill-count readout logic absent; data path unchanged.

Structure
REQ-027 Shared package SHALL hold RESP_OKAY (2'b00), region encodings, status empty-bit position.
REQ-028 One sub-module axi_axis_mc_fifo (single-channel FIFO with push, pop, flush, count, full, empty), instantiated CHANNELS times.

Verification (CHANNELS=4, FIFO_DEPTH=4, W=32)
REQ-029 Push 0xA1,0xA2 on ch2; read 0x008 twice then once more -> 0xA1, 0xA2, 0x00000000; rresp 0.
REQ-030 Push 5 beats on ch0 with no reads -> 4 accepted, tready[0]=0; status read 0x010 -> 0x00000004; one data read -> tready[0]=1 next cycle.
REQ-031 Empty ch3 status read 0x01C -> 0x80000000; write 0x014 wdata=1 after filling ch1 to 3 -> status 0x014 reads 0x80000000, bvalid one cycle after accept.
REQ-032 Hold rready=0 after read -> rvalid stays 1, arready 0, rdata stable; next ar accepted the cycle after rready.
REQ-033 Assert areset with rvalid=1 and ch0 count 2 -> rvalid 0, status 0x010 after release reads 0x80000000.
REQ-034 Build without AXI_AXIS_MC_READER_STATUS_EN -> read 0x010 returns 0; flush write leaves data readable.
